sub_pipe_16bit: RTL and testbench

Pipelined 16-bit subtractor with borrow-in/borrow-out. It is the subtract-side counterpart to the team's 16-bit carry-select adder and feeds the ALU's SUB/CMP path. Operands are processed one 4-bit nibble per pipeline stage, and each nibble is resolved carry-select style from the registered borrow of the previous stage. The block accepts one operation per cycle under a valid/ready handshake with full backpressure.

---
 rtl/sub_pipe_16bit.sv | 136 +++++++++++++
 tb/tb_sub_pipe_16bit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_pipe_16bit.sv
// Pipelined 16-bit subtractor (a - b - b_in), one nibble per stage, carry-select
// resolution from the registered borrow, valid/ready handshake with backpressure.
module sub_pipe_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        b_out,
  output logic        ovf,
  output logic        zero
);

  localparam int unsigned NIB_W = 4;

  // Nibble add of x + y, resolved carry-select style: both carry-ins, then a 2:1 pick.
  function automatic logic [NIB_W:0] nib_add(input logic [NIB_W-1:0] x,
                                             input logic [NIB_W-1:0] y,
                                             input logic             cin);
    logic [NIB_W:0] sum_c0;
    logic [NIB_W:0] sum_c1;
    sum_c0 = {1'b0, x} + {1'b0, y};
    sum_c1 = {1'b0, x} + {1'b0, y} + (NIB_W+1)'(1);
    return cin ? sum_c1 : sum_c0;
  endfunction

  logic advance;

  // S0: raw operands and carry into nibble 0
  logic        v0;
  logic        c0;
  logic [15:0] a0;
  logic [15:0] b0;
  // S1..S3: carry into nibble k, resolved low nibbles, remaining operand nibbles
  logic        v1;
  logic        c1;
  logic [3:0]  d1;
  logic [11:0] a1;
  logic [11:0] b1;
  logic        v2;
  logic        c2;
  logic [7:0]  d2;
  logic [7:0]  a2;
  logic [7:0]  b2;
  logic        v3;
  logic        c3;
  logic [11:0] d3;
  logic [3:0]  a3;
  logic [3:0]  b3;

  logic [4:0]  n0;
  logic [4:0]  n1;
  logic [4:0]  n2;
  logic [4:0]  n3;
  logic [15:0] diff_nxt;
  logic        c15;
  logic        c16;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign n0 = nib_add(a0[3:0], ~b0[3:0], c0);
  assign n1 = nib_add(a1[3:0], ~b1[3:0], c1);
  assign n2 = nib_add(a2[3:0], ~b2[3:0], c2);
  assign n3 = nib_add(a3,      ~b3,      c3);

  // c15 recovered from the sum bit: s15 = a15 ^ ~b15 ^ c15
  assign diff_nxt = {n3[3:0], d3};
  assign c16      = n3[4];
  assign c15      = a3[3] ^ ~b3[3] ^ n3[3];

  // Whole pipeline shifts together when advance is high, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      c0        <= 1'b0;
      a0        <= '0;
      b0        <= '0;
      v1        <= 1'b0;
      c1        <= 1'b0;
      d1        <= '0;
      a1        <= '0;
      b1        <= '0;
      v2        <= 1'b0;
      c2        <= 1'b0;
      d2        <= '0;
      a2        <= '0;
      b2        <= '0;
      v3        <= 1'b0;
      c3        <= 1'b0;
      d3        <= '0;
      a3        <= '0;
      b3        <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      v0        <= in_valid;
      c0        <= ~b_in;
      a0        <= a;
      b0        <= b;

      v1        <= v0;
      c1        <= n0[4];
      d1        <= n0[3:0];
      a1        <= a0[15:4];
      b1        <= b0[15:4];

      v2        <= v1;
      c2        <= n1[4];
      d2        <= {n1[3:0], d1};
      a2        <= a1[11:4];
      b2        <= b1[11:4];

      v3        <= v2;
      c3        <= n2[4];
      d3        <= {n2[3:0], d2};
      a3        <= a2[7:4];
      b3        <= b2[7:4];

      out_valid <= v3;
      diff      <= diff_nxt;
      b_out     <= ~c16;
      ovf       <= c15 ^ c16;
      zero      <= (diff_nxt == 16'h0000);
    end
  end

endmodule

// File: tb/tb_sub_pipe_16bit.sv
// Scoreboard bench for sub_pipe_16bit: directed vectors, backpressure, bubbles, reset.
module tb_sub_pipe_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        b_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        b_out;
  logic        ovf;
  logic        zero;

  sub_pipe_16bit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] r;     // {diff, b_out, ovf, zero}
    logic        lat;   // check 4-edge latency for this op
    int          acc;   // edge number of acceptance
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        stalled = 1'b0;
  logic [18:0] held = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance: handshake seen at negedge completes on the following posedge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e     = cur;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
  end

  // Monitor: handshake rule, stall stability, in-order result check
  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      exp_rdy = ~out_valid | out_ready;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (stalled && out_valid)
        check("stall_hold", 32'({diff, b_out, ovf, zero}), 32'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got diff %h with empty scoreboard", diff);
        end else begin
          e = sb.pop_front();
          check("result", 32'({diff, b_out, ovf, zero}), 32'(e.r));
          if (e.lat) check("latency", 32'(cyc - e.acc), 32'd4);
        end
      end
      stalled = out_valid && !out_ready;
      held    = {diff, b_out, ovf, zero};
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbi,
                      input logic [15:0] ed, input logic eb, input logic eo,
                      input logic ez, input logic lat);
    int g;
    @(posedge clk);
    #1;
    a        = ta;
    b        = tb;
    b_in     = tbi;
    in_valid = 1'b1;
    cur.r    = {ed, eb, eo, ez};
    cur.lat  = lat;
    cur.acc  = 0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!in_ready && g < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", g);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs",   32'({diff, b_out, ovf, zero}), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;

    // Simple subtract, underflow/overflow, borrow-in and zero
    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
    send(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
    send(16'h00FF, 16'h00FE, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'h00FF, 16'h00FE, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();

    // Backpressure: 8 back-to-back ops while out_ready stalls then toggles
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(16'(i), 16'h0001, 1'b0, 16'(i - 1), 1'b0, 1'b0, (i == 1), 1'b0);
        idle();
      end
      begin
        int g;
        g = 0;
        while (!out_valid && g < 100) begin
          @(posedge clk);
          #1;
          g++;
        end
        if (!out_valid) begin
          checks++;
          errors++;
          $display("FAIL bp_first_valid: out_valid never rose");
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        repeat (30) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Bubbles: alternate in_valid with out_ready held high
    for (int i = 0; i < 6; i++) begin
      send(16'h0010, 16'(i), 1'b0, 16'(16 - i), 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
    end
    wait_drain();

    // Reset mid-flight: three in flight, none may surface afterwards
    send(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h2222, 16'h0002, 1'b0, 16'h2220, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h3333, 16'h0003, 1'b0, 16'h3330, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs",   32'({diff, b_out, ovf, zero}), 32'd0);
    check("midrst_in_ready",  32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_drain();
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
